// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types, defaults and lane helper for the systolic array front end
package systolic_pkg;

  localparam int N_DEFAULT          = 3;
  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;

  // Lane carries element t-lane of its row/column; written without subtraction to avoid underflow.
  function automatic logic lane_active(input int t, input int lane, input int n);
    return (t >= lane) && (t < lane + n);
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - load port and skewed lane outputs of the systolic feeder
interface systolic_feeder_if
  import systolic_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);
  logic                    load_valid;
  logic                    load_ready;
  logic [N*DATA_WIDTH-1:0] a_row;
  logic [N*DATA_WIDTH-1:0] b_col;
  logic [DATA_WIDTH-1:0]   a_out_bus [N-1:0];
  logic [N-1:0]            valid_bit_a_out;
  logic [DATA_WIDTH-1:0]   b_out_bus [N-1:0];
  logic [N-1:0]            valid_bit_b_out;
  logic                    busy;
  logic                    done;

  modport master (
    output load_valid, a_row, b_col,
    input  load_ready, a_out_bus, valid_bit_a_out, b_out_bus, valid_bit_b_out, busy, done
  );

  modport slave (
    input  load_valid, a_row, b_col,
    output load_ready, a_out_bus, valid_bit_a_out, b_out_bus, valid_bit_b_out, busy, done
  );
endinterface

// File: rtl/feeder_matrix_buf.sv
// rtl/feeder_matrix_buf.sv - NxN operand bank, row write port, combinational diagonal read
module feeder_matrix_buf
  import systolic_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
)(
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [$clog2(N+1)-1:0]  wr_row,
  input  logic [N*DATA_WIDTH-1:0] wr_data,
  input  logic [$clog2(2*N)-1:0]  rd_t,
  output logic [DATA_WIDTH-1:0]   rd_data [N-1:0]
);
  localparam int RW = $clog2(N + 1);

  logic [DATA_WIDTH-1:0] mem_q [N-1:0][N-1:0];
  logic [DATA_WIDTH-1:0] mem_d [N-1:0][N-1:0];

  always_comb begin
    mem_d = mem_q;
    for (int r = 0; r < N; r++) begin
      if (wr_en && (wr_row == RW'(r))) begin
        for (int k = 0; k < N; k++) begin
          mem_d[r][k] = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Lane i reads storage row i at column t-i; inactive lanes read as zero padding.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rd_data[i] = '0;
      for (int k = 0; k < N; k++) begin
        if (lane_active(int'(rd_t), i, N) && (int'(rd_t) == i + k)) begin
          rd_data[i] = mem_q[i][k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - buffers an A/B matrix pair and replays it as skewed wavefronts
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
)(
  input  logic              clk,
  input  logic              rst,
  systolic_feeder_if.slave  io
);
  localparam int RW = $clog2(N + 1);
  localparam int TW = $clog2(2 * N);

  feeder_state_t         state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [TW-1:0]         t_q, t_d;
  logic [TW-1:0]         rd_t;
  logic                  accept;
  logic                  load_wave;

  logic [DATA_WIDTH-1:0] rd_a [N-1:0];
  logic [DATA_WIDTH-1:0] rd_b [N-1:0];
  logic [DATA_WIDTH-1:0] a_out_q [N-1:0];
  logic [DATA_WIDTH-1:0] a_out_d [N-1:0];
  logic [DATA_WIDTH-1:0] b_out_q [N-1:0];
  logic [DATA_WIDTH-1:0] b_out_d [N-1:0];
  logic [N-1:0]          va_q, va_d, vb_q, vb_d;
  logic                  busy_q, busy_d, done_q, done_d;

  assign io.load_ready = (state_q == LOAD);
  assign accept        = io.load_valid && io.load_ready && !rst;

  // Outputs are registered, so the bank is read one wavefront ahead of what is displayed.
  assign rd_t = (state_q == STREAM) ? t_q + TW'(1) : '0;

  // Column r of B lands in storage row r, so B is held transposed and read like A.
  feeder_matrix_buf #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_a_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_row  (row_q),
    .wr_data (io.a_row),
    .rd_t    (rd_t),
    .rd_data (rd_a)
  );

  feeder_matrix_buf #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_b_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_row  (row_q),
    .wr_data (io.b_col),
    .rd_t    (rd_t),
    .rd_data (rd_b)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    t_d       = t_q;
    load_wave = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_out_d[i] = '0;
      b_out_d[i] = '0;
    end
    va_d = '0;
    vb_d = '0;

    case (state_q)
      LOAD: begin
        if (accept) begin
          if (row_q == RW'(N - 1)) begin
            state_d   = STREAM;
            row_d     = '0;
            t_d       = '0;
            load_wave = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      STREAM: begin
        if (t_q == TW'(2 * N - 2)) begin
          state_d = DONE;
        end else begin
          t_d       = t_q + TW'(1);
          load_wave = 1'b1;
        end
      end
      DONE: begin
        state_d = LOAD;
        row_d   = '0;
        t_d     = '0;
      end
      default: begin
        state_d = LOAD;
        row_d   = '0;
        t_d     = '0;
      end
    endcase

    if (load_wave) begin
      for (int i = 0; i < N; i++) begin
        a_out_d[i] = rd_a[i];
        b_out_d[i] = rd_b[i];
        va_d[i]    = lane_active(int'(rd_t), i, N);
        vb_d[i]    = lane_active(int'(rd_t), i, N);
      end
    end

    busy_d = (state_d != LOAD);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      row_q   <= '0;
      t_q     <= '0;
      for (int i = 0; i < N; i++) begin
        a_out_q[i] <= '0;
        b_out_q[i] <= '0;
      end
      va_q    <= '0;
      vb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      t_q     <= t_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign io.a_out_bus       = a_out_q;
  assign io.b_out_bus       = b_out_q;
  assign io.valid_bit_a_out = va_q;
  assign io.valid_bit_b_out = vb_q;
  assign io.busy            = busy_q;
  assign io.done            = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed self-checking bench for systolic_feeder, N=3, 8-bit data
module tb_systolic_feeder;
  typedef logic [7:0] mat_t [3][3];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  mat_t ma, ident, mb, mc, mff;

  systolic_feeder_if #(.N(3), .DATA_WIDTH(8)) io ();

  systolic_feeder #(.N(3), .DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input mat_t a, input mat_t b, input int r);
    io.load_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      io.a_row[k*8 +: 8] = a[r][k];
      io.b_col[k*8 +: 8] = b[k][r];
    end
  endtask

  function automatic logic [7:0] exp_a(input mat_t a, input int t, input int i);
    return (t >= i && t < i + 3) ? a[i][t-i] : 8'h00;
  endfunction

  function automatic logic [7:0] exp_b(input mat_t b, input int t, input int j);
    return (t >= j && t < j + 3) ? b[t-j][j] : 8'h00;
  endfunction

  function automatic logic [2:0] exp_v(input int t);
    logic [2:0] v;
    for (int i = 0; i < 3; i++) v[i] = (t >= i && t < i + 3);
    return v;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (io.a_out_bus[i] !== 8'h00 || io.b_out_bus[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset_data lane=%0d a=%0h b=%0h want 0", i, io.a_out_bus[i], io.b_out_bus[i]);
      end
    end
    checks++;
    if (io.valid_bit_a_out !== 3'b000 || io.valid_bit_b_out !== 3'b000 || io.busy !== 1'b0 ||
        io.done !== 1'b0 || io.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl va=%b vb=%b busy=%b done=%b ready=%b want 000 000 0 0 1",
               io.valid_bit_a_out, io.valid_bit_b_out, io.busy, io.done, io.load_ready);
    end
  endtask

  task automatic test_basic;
    logic [7:0] ea [5][3];
    logic [7:0] eb [5][3];
    logic [2:0] ev [5];
    ea = '{'{8'd1, 8'd0, 8'd0}, '{8'd2, 8'd4, 8'd0}, '{8'd3, 8'd5, 8'd7},
           '{8'd0, 8'd6, 8'd8}, '{8'd0, 8'd0, 8'd9}};
    eb = '{'{8'd1, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd1, 8'd0},
           '{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd1}};
    ev = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100};
    for (int r = 0; r < 3; r++) begin
      drive_beat(ma, ident, r);
      checks++;
      if (io.load_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_ready beat=%0d got %b want 1", r, io.load_ready);
      end
      tick;
    end
    io.load_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (io.a_out_bus[i] !== ea[t][i] || io.b_out_bus[i] !== eb[t][i]) begin
          errors++;
          $display("FAIL basic_data t=%0d lane=%0d a=%0d want %0d b=%0d want %0d",
                   t, i, io.a_out_bus[i], ea[t][i], io.b_out_bus[i], eb[t][i]);
        end
      end
      checks++;
      if (io.valid_bit_a_out !== ev[t] || io.valid_bit_b_out !== ev[t] ||
          io.busy !== 1'b1 || io.done !== 1'b0 || io.load_ready !== 1'b0) begin
        errors++;
        $display("FAIL basic_valid t=%0d va=%b vb=%b want %b busy=%b done=%b ready=%b",
                 t, io.valid_bit_a_out, io.valid_bit_b_out, ev[t], io.busy, io.done, io.load_ready);
      end
      tick;
    end
    checks++;
    if (io.done !== 1'b1 || io.busy !== 1'b1 || io.load_ready !== 1'b0 ||
        io.valid_bit_a_out !== 3'b000 || io.a_out_bus[2] !== 8'h00) begin
      errors++;
      $display("FAIL basic_done done=%b busy=%b ready=%b va=%b a2=%0h want 1 1 0 000 0",
               io.done, io.busy, io.load_ready, io.valid_bit_a_out, io.a_out_bus[2]);
    end
    tick;
    checks++;
    if (io.done !== 1'b0 || io.busy !== 1'b0 || io.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle done=%b busy=%b ready=%b want 0 0 1", io.done, io.busy, io.load_ready);
    end
  endtask

  task automatic test_gapped;
    drive_beat(ma, ident, 0);
    tick;
    io.load_valid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      tick;
      checks++;
      if (io.load_ready !== 1'b1 || io.busy !== 1'b0 || io.valid_bit_a_out !== 3'b000) begin
        errors++;
        $display("FAIL gap_idle g=%0d ready=%b busy=%b va=%b want 1 0 000",
                 g, io.load_ready, io.busy, io.valid_bit_a_out);
      end
    end
    drive_beat(ma, ident, 1);
    tick;
    drive_beat(ma, ident, 2);
    tick;
    io.load_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (io.a_out_bus[i] !== exp_a(ma, t, i) || io.b_out_bus[i] !== exp_b(ident, t, i)) begin
          errors++;
          $display("FAIL gap_data t=%0d lane=%0d a=%0h want %0h b=%0h want %0h", t, i,
                   io.a_out_bus[i], exp_a(ma, t, i), io.b_out_bus[i], exp_b(ident, t, i));
        end
      end
      checks++;
      if (io.valid_bit_a_out !== exp_v(t) || io.valid_bit_b_out !== exp_v(t)) begin
        errors++;
        $display("FAIL gap_valid t=%0d va=%b vb=%b want %b", t, io.valid_bit_a_out, io.valid_bit_b_out, exp_v(t));
      end
      tick;
    end
    checks++;
    if (io.done !== 1'b1) begin
      errors++;
      $display("FAIL gap_done got %b want 1", io.done);
    end
    tick;
  endtask

  task automatic test_hold_valid;
    for (int r = 0; r < 3; r++) begin
      drive_beat(ma, ident, r);
      tick;
    end
    drive_beat(mc, mb, 0);
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (io.a_out_bus[i] !== exp_a(ma, t, i) || io.b_out_bus[i] !== exp_b(ident, t, i)) begin
          errors++;
          $display("FAIL hold_data1 t=%0d lane=%0d a=%0h want %0h b=%0h want %0h", t, i,
                   io.a_out_bus[i], exp_a(ma, t, i), io.b_out_bus[i], exp_b(ident, t, i));
        end
      end
      checks++;
      if (io.load_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_ready_stream t=%0d got %b want 0", t, io.load_ready);
      end
      tick;
    end
    checks++;
    if (io.done !== 1'b1 || io.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_done done=%b ready=%b want 1 0", io.done, io.load_ready);
    end
    tick;
    checks++;
    if (io.load_ready !== 1'b1 || io.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_reload ready=%b busy=%b want 1 0", io.load_ready, io.busy);
    end
    tick;
    drive_beat(mc, mb, 1);
    tick;
    drive_beat(mc, mb, 2);
    tick;
    io.load_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (io.a_out_bus[i] !== exp_a(mc, t, i) || io.b_out_bus[i] !== exp_b(mb, t, i) ||
            io.valid_bit_a_out[i] !== exp_v(t)[i]) begin
          errors++;
          $display("FAIL hold_data2 t=%0d lane=%0d a=%0h want %0h b=%0h want %0h va=%b", t, i,
                   io.a_out_bus[i], exp_a(mc, t, i), io.b_out_bus[i], exp_b(mb, t, i), io.valid_bit_a_out);
        end
      end
      tick;
    end
    checks++;
    if (io.done !== 1'b1) begin
      errors++;
      $display("FAIL hold_done2 got %b want 1", io.done);
    end
    tick;
  endtask

  task automatic test_reset_mid_stream;
    for (int r = 0; r < 3; r++) begin
      drive_beat(ma, ident, r);
      tick;
    end
    io.load_valid = 1'b0;
    tick;
    tick;
    checks++;
    if (io.a_out_bus[2] !== 8'd7 || io.valid_bit_a_out !== 3'b111) begin
      errors++;
      $display("FAIL rst_pre a2=%0d want 7 va=%b want 111", io.a_out_bus[2], io.valid_bit_a_out);
    end
    rst = 1'b1;
    drive_beat(mc, mb, 0);
    tick;
    rst = 1'b0;
    io.load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (io.a_out_bus[i] !== 8'h00 || io.b_out_bus[i] !== 8'h00) begin
        errors++;
        $display("FAIL rst_data lane=%0d a=%0h b=%0h want 0", i, io.a_out_bus[i], io.b_out_bus[i]);
      end
    end
    checks++;
    if (io.valid_bit_a_out !== 3'b000 || io.valid_bit_b_out !== 3'b000 || io.busy !== 1'b0 ||
        io.done !== 1'b0 || io.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ctrl va=%b vb=%b busy=%b done=%b ready=%b want 000 000 0 0 1",
               io.valid_bit_a_out, io.valid_bit_b_out, io.busy, io.done, io.load_ready);
    end
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++;
      if (io.done !== 1'b0 || io.valid_bit_a_out !== 3'b000) begin
        errors++;
        $display("FAIL rst_quiet c=%0d done=%b va=%b want 0 000", c, io.done, io.valid_bit_a_out);
      end
    end
    for (int r = 0; r < 3; r++) begin
      drive_beat(mc, mb, r);
      tick;
    end
    io.load_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (io.a_out_bus[i] !== exp_a(mc, t, i) || io.b_out_bus[i] !== exp_b(mb, t, i)) begin
          errors++;
          $display("FAIL rst_fresh t=%0d lane=%0d a=%0h want %0h b=%0h want %0h", t, i,
                   io.a_out_bus[i], exp_a(mc, t, i), io.b_out_bus[i], exp_b(mb, t, i));
        end
      end
      tick;
    end
    checks++;
    if (io.done !== 1'b1) begin
      errors++;
      $display("FAIL rst_fresh_done got %b want 1", io.done);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 3; r++) begin
      drive_beat(ma, ident, r);
      tick;
    end
    io.load_valid = 1'b0;
    repeat (5) tick;
    checks++;
    if (io.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done1 got %b want 1", io.done);
    end
    tick;
    for (int r = 0; r < 3; r++) begin
      drive_beat(mff, mb, r);
      tick;
    end
    io.load_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (io.a_out_bus[i] !== exp_a(mff, t, i) || io.b_out_bus[i] !== exp_b(mb, t, i) ||
            io.valid_bit_a_out[i] !== exp_v(t)[i]) begin
          errors++;
          $display("FAIL b2b_data t=%0d lane=%0d a=%0h want %0h b=%0h want %0h va=%b", t, i,
                   io.a_out_bus[i], exp_a(mff, t, i), io.b_out_bus[i], exp_b(mb, t, i), io.valid_bit_a_out);
        end
      end
      tick;
    end
    checks++;
    if (io.done !== 1'b1 || io.a_out_bus[0] !== 8'h00) begin
      errors++;
      $display("FAIL b2b_done2 done=%b a0=%0h want 1 0", io.done, io.a_out_bus[0]);
    end
    tick;
  endtask

  initial begin
    io.load_valid = 1'b0;
    io.a_row      = '0;
    io.b_col      = '0;
    ma    = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}, '{8'd7, 8'd8, 8'd9}};
    ident = '{'{8'd1, 8'd0, 8'd0}, '{8'd0, 8'd1, 8'd0}, '{8'd0, 8'd0, 8'd1}};
    mb    = '{'{8'd21, 8'd22, 8'd23}, '{8'd24, 8'd25, 8'd26}, '{8'd27, 8'd28, 8'd29}};
    mc    = '{'{8'd10, 8'd11, 8'd12}, '{8'd13, 8'd14, 8'd15}, '{8'd16, 8'd17, 8'd18}};
    mff   = '{'{8'hFF, 8'hFF, 8'hFF}, '{8'hFF, 8'hFF, 8'hFF}, '{8'hFF, 8'hFF, 8'hFF}};
    test_reset;
    test_basic;
    test_gapped;
    test_hold_valid;
    test_reset_mid_stream;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Input-side transmitter for the `dense_mult` systolic array. Accepts an N×N operand matrix A (row per beat) and B (column per beat) over a valid/ready load port and buffers both. It then replays them as skewed wavefronts: lane i delayed i cycles, with per-lane valid bits. Its outputs connect directly to the array's A/B lane inputs.

## Interface
- `N`, 3: matrix dimension and lane count (N ≥ 2).
- `DATA_WIDTH`, 8: operand element width.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `load_valid`  in  1: load beat offered.
- `load_ready`  out  1: feeder accepts a beat; high only in state LOAD.
- `a_row`  in  N*DATA_WIDTH: row r of A; element k in bits [k*DATA_WIDTH +: DATA_WIDTH].
- `b_col`  in  N*DATA_WIDTH: column r of B; element k (row k) is at the same slice.
- `a_out_bus`  out  [N-1:0] × DATA_WIDTH: A lane data, unpacked array.
- `valid_bit_a_out`  out  [N-1:0] × 1: A lane valid.
- `b_out_bus`  out  [N-1:0] × DATA_WIDTH: B lane data.
- `valid_bit_b_out`  out  [N-1:0] × 1: B lane valid.
- `busy`  out  1: high in STREAM and DONE.
- `done`  out  1: single-cycle pulse after the final wavefront.

## Operation
- States: LOAD → STREAM → DONE → LOAD.
- LOAD
  - `load_ready`=1.
  - A beat is accepted when `load_valid`&&`load_ready` at the clock edge.
  - Beat r writes A[r][*]←`a_row` and B[*][r]←`b_col`; the row counter increments.
  - Acceptance of beat N-1 moves to STREAM with wavefront counter t=0.
- STREAM lasts 2N-1 cycles, t = 0 … 2N-2.
  - A lane i: data A[i][t-i], valid 1 when 0 ≤ t-i < N; otherwise data 0, valid 0.
  - B lane j: data B[t-j][j], valid 1 when 0 ≤ t-j < N; otherwise data 0, valid 0.
  - t=2N-2 moves to DONE.
- DONE, one cycle
  - `done`=1.
  - All lanes data 0, valid 0.
  - `load_ready`=0.
  - Next state LOAD, row counter 0.
- `load_valid` outside LOAD is ignored. No beat is consumed and buffers are unchanged.
- There is no backpressure from the array. Once STREAM starts, it runs to completion.
- Invalid lanes always carry data 0 (zero padding the array relies on).
- Counter widths: row counter $clog2(N+1), wavefront counter $clog2(2N). Comparisons are unsigned. Evaluate the t-i test as t ≥ i and t < i+N so there is no signed underflow.

## Timing
- All lane outputs, valid bits, `busy` and `done` are registers. `load_ready` is decoded from the state register.
- Reset values
  - State LOAD, both counters 0.
  - All `*_out_bus`=0, all valid bits=0.
  - `busy`=0, `done`=0, `load_ready`=1 (visible the cycle after reset deasserts).
  - Buffer contents are not reset.
- Latency
  - The wavefront t=0 appears on the outputs in the cycle immediately after the edge that accepts beat N-1.
  - Wavefront t appears t cycles after that.
  - `done` is asserted 2N-1 cycles after t=0 appears.
- Throughput: one matrix pair per N + (2N-1) + 1 cycles. The next LOAD beat can be accepted in the cycle after `done`.
- `rst` asserted in any state, including mid-STREAM, takes effect at the next edge: outputs go to zero and invalid, state becomes LOAD, and the partially loaded matrix is discarded.
- `rst` and `load_valid` in the same cycle: reset wins and no beat is accepted.

## Structure
- Package `systolic_pkg`:
  - `feeder_state_t` enum {LOAD, STREAM, DONE}.
  - Default `N`/`DATA_WIDTH` localparams shared with `dense_mult`.
  - Helper function `lane_active(t, lane, N)`.
- Sub-module `feeder_matrix_buf`: N×N register bank with a row-write port and a combinational diagonal-read port (index t-lane per lane). Instantiated twice, for A and for B (B written transposed).
- Top level holds the FSM, counters and output registers.

## Test plan
- Reset, then idle → all lanes 0, all valid 0, `busy`=0, `done`=0, `load_ready`=1.
- N=3, A=[[1,2,3],[4,5,6],[7,8,9]], B=I, three back-to-back beats → A lanes in order:
  - t=0: {1,0,0}, valid {1,0,0}
  - t=1: {2,4,0}, valid {1,1,0}
  - t=2: {3,5,7}, valid {1,1,1}
  - t=3: {0,6,8}, valid {0,1,1}
  - t=4: {0,0,9}, valid {0,0,1}
  - B lanes for the same run: lane0=1 at t=0, lane1=1 at t=2, lane2=1 at t=4. All other B data is 0; B valid follows the same diagonal pattern as A.
  - `done` high in the cycle after t=4.
- Load with `load_valid` gapped (beats in cycles 0, 3, 4) → identical output sequence. t=0 appears the cycle after the cycle-4 beat.
- `load_valid` held high during STREAM/DONE → `load_ready`=0, no row counter change. The second matrix loads only after `done`, and its wavefront matches its own data.
- `rst` pulsed at t=2 → next cycle all lanes zero and invalid, `done` never pulses. A fresh 3-beat load then streams correctly.
- Two matrices back-to-back, second A=all 0xFF → the first `done` is followed by the LOAD phase. The second wavefront shows 0xFF only on valid lanes, with no carry-over from the first matrix.
